// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter: cascaded decades with ripple carry/borrow,
// parallel load with per-digit clamp to 9, wrap or saturate at the ends.
module bcd_updown_counter #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   out,
    output logic                  tc
);

    logic [4*DIGITS-1:0] r_out;
    logic [4*DIGITS-1:0] w_step;
    logic [4*DIGITS-1:0] w_load;
    logic [DIGITS:0]     w_chain;
    logic [DIGITS-1:0]   w_is9;
    logic [DIGITS-1:0]   w_is0;
    logic                w_all9;
    logic                w_all0;
    logic                w_sat;

    // w_chain[k] is the carry (up) or borrow (down) entering digit k.
    assign w_chain[0] = 1'b1;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            logic [3:0] w_d;
            logic [3:0] w_lv;
            assign w_d      = r_out[4*k +: 4];
            assign w_lv     = load_val[4*k +: 4];
            assign w_is9[k] = (w_d == 4'd9);
            assign w_is0[k] = (w_d == 4'd0);

            always_comb begin
                w_step[4*k +: 4] = w_d;
                if (w_chain[k]) begin
                    if (up) w_step[4*k +: 4] = w_is9[k] ? 4'd0 : w_d + 4'd1;
                    else    w_step[4*k +: 4] = w_is0[k] ? 4'd9 : w_d - 4'd1;
                end
            end

            assign w_chain[k+1]     = w_chain[k] & (up ? w_is9[k] : w_is0[k]);
            assign w_load[4*k +: 4] = (w_lv > 4'd9) ? 4'd9 : w_lv;
        end
    endgenerate

    assign w_all9 = &w_is9;
    assign w_all0 = &w_is0;
    // A carry/borrow out of the top digit means we are at an end of the range.
    assign w_sat  = !WRAP && w_chain[DIGITS];

    always_ff @(posedge clk) begin
        if (rst)
            r_out <= '0;
        else if (load)
            r_out <= w_load;
        else if (en && !w_sat)
            r_out <= w_step;
    end

    assign out = r_out;
    assign tc  = en & ~load & ((up & w_all9) | (~up & w_all0));

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three instances (2-digit wrap, 2-digit saturate,
// 3-digit wrap) driven from vector tables and short hand sequences.
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_v, load_v, en_v, up_v;
    logic [2:0][11:0] lv_v;
    logic [7:0]       out_a, out_b;
    logic [11:0]      out_c;
    logic             tc_a, tc_b, tc_c;

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_a (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .up(up_v[0]), .load(load_v[0]),
        .load_val(lv_v[0][7:0]), .out(out_a), .tc(tc_a));
    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) u_b (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .up(up_v[1]), .load(load_v[1]),
        .load_val(lv_v[1][7:0]), .out(out_b), .tc(tc_b));
    bcd_updown_counter #(.DIGITS(3), .WRAP(1'b1)) u_c (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .up(up_v[2]), .load(load_v[2]),
        .load_val(lv_v[2]), .out(out_c), .tc(tc_c));

    int n_total = 0;
    int n_pass  = 0;
    logic [11:0] exp_q[$];

    typedef struct {
        logic        r, ld, e, u;
        logic [11:0] lv;
        logic [11:0] eo;
        logic        etc;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [11:0] get_out(input int d);
        case (d)
            0:       return {4'h0, out_a};
            1:       return {4'h0, out_b};
            default: return out_c;
        endcase
    endfunction

    function automatic logic get_tc(input int d);
        case (d)
            0:       return tc_a;
            1:       return tc_b;
            default: return tc_c;
        endcase
    endfunction

    function automatic logic [11:0] bcd(input int n);
        return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Drive one cycle: tc checked combinationally before the edge, out after it.
    task automatic step(input int d, input logic r, ld, e, u, input logic [11:0] lv,
                        input logic [11:0] eo, input logic etc, input string nm);
        logic [11:0] exp_o;
        rst_v[d] = r; load_v[d] = ld; en_v[d] = e; up_v[d] = u; lv_v[d] = lv;
        #1;
        check({nm, ".tc"}, {11'd0, get_tc(d)}, {11'd0, etc});
        exp_q.push_back(eo);
        @(posedge clk); #1;
        exp_o = exp_q.pop_front();
        check({nm, ".out"}, get_out(d), exp_o);
        rst_v[d] = 1'b0; load_v[d] = 1'b0; en_v[d] = 1'b0;
    endtask

    function automatic void add(input logic r, ld, e, u, input logic [11:0] lv,
                                input logic [11:0] eo, input logic etc);
        vec_t v;
        v.r = r; v.ld = ld; v.e = e; v.u = u; v.lv = lv; v.eo = eo; v.etc = etc;
        tbl.push_back(v);
    endfunction

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v = '1; load_v = '0; en_v = '0; up_v = '0; lv_v = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_a", get_out(0), 12'h000);
        check("rst.out_b", get_out(1), 12'h000);
        check("rst.out_c", get_out(2), 12'h000);
        check("rst.tc_a", {11'd0, tc_a}, 12'h000);
        rst_v = '0;

        // en=1, up=0 right after reset: tc immediately high (wrap mode steps to 99)
        step(0, 0, 0, 1, 0, 12'h0, 12'h099, 1'b1, "tc_after_rst");
        step(0, 1, 0, 0, 0, 12'h0, 12'h000, 1'b0, "rst_again");

        // Full count 00..99,00
        for (int n = 0; n < 100; n++)
            step(0, 0, 0, 1, 1, 12'h0, bcd((n + 1) % 100), n == 99, "count_up");

        // Table: decrement wrap, load priority/sanitise, enable/direction mix
        add(0, 1, 0, 0, 12'h005, 12'h005, 0);
        add(0, 0, 1, 0, 12'h000, 12'h004, 0);
        add(0, 0, 1, 0, 12'h000, 12'h003, 0);
        add(0, 0, 1, 0, 12'h000, 12'h002, 0);
        add(0, 0, 1, 0, 12'h000, 12'h001, 0);
        add(0, 0, 1, 0, 12'h000, 12'h000, 0);
        add(0, 0, 1, 0, 12'h000, 12'h099, 1);
        add(0, 0, 1, 0, 12'h000, 12'h098, 0);
        add(0, 1, 1, 1, 12'h0A3, 12'h093, 0);
        add(0, 0, 1, 1, 12'h000, 12'h094, 0);
        add(0, 1, 0, 0, 12'h0FC, 12'h099, 0);
        add(0, 1, 0, 0, 12'h010, 12'h010, 0);
        add(0, 0, 1, 0, 12'h000, 12'h009, 0);
        add(0, 0, 0, 1, 12'h000, 12'h009, 0);
        add(0, 0, 1, 1, 12'h000, 12'h010, 0);
        add(0, 0, 1, 1, 12'h000, 12'h011, 0);
        add(0, 0, 1, 0, 12'h000, 12'h010, 0);
        add(0, 0, 0, 1, 12'h000, 12'h010, 0);
        add(1, 1, 1, 1, 12'h055, 12'h000, 0);
        for (int i = 0; i < tbl.size(); i++)
            step(0, tbl[i].r, tbl[i].ld, tbl[i].e, tbl[i].u, tbl[i].lv,
                 tbl[i].eo, tbl[i].etc, $sformatf("vec%0d", i));

        // Saturate mode: hold at 99 with tc, then step back down; hold at 00
        step(1, 0, 1, 0, 0, 12'h098, 12'h098, 1'b0, "sat.load");
        step(1, 0, 0, 1, 1, 12'h000, 12'h099, 1'b0, "sat.up0");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 1, 1, 12'h000, 12'h099, 1'b1, "sat.hold9");
        step(1, 0, 0, 1, 0, 12'h000, 12'h098, 1'b0, "sat.down");
        step(1, 0, 1, 0, 0, 12'h000, 12'h000, 1'b0, "sat.load0");
        step(1, 0, 0, 1, 0, 12'h000, 12'h000, 1'b1, "sat.hold0");
        step(1, 0, 0, 1, 1, 12'h000, 12'h001, 1'b0, "sat.up_from0");

        // Three digits: count to 457, reset beats load, full-width carry/borrow
        step(2, 0, 1, 0, 0, 12'h450, 12'h450, 1'b0, "d3.load");
        for (int i = 1; i <= 7; i++)
            step(2, 0, 0, 1, 1, 12'h000, 12'h450 + 12'(i), 1'b0, "d3.up");
        step(2, 1, 1, 1, 1, 12'h321, 12'h000, 1'b0, "d3.rst_vs_load");
        step(2, 0, 0, 1, 1, 12'h000, 12'h001, 1'b0, "d3.resume");
        step(2, 0, 1, 0, 0, 12'h199, 12'h199, 1'b0, "d3.load199");
        step(2, 0, 0, 1, 1, 12'h000, 12'h200, 1'b0, "d3.ripple");
        step(2, 0, 1, 0, 0, 12'h999, 12'h999, 1'b0, "d3.load999");
        step(2, 0, 0, 1, 1, 12'h000, 12'h000, 1'b1, "d3.wrap_up");
        step(2, 0, 0, 1, 0, 12'h000, 12'h999, 1'b1, "d3.wrap_dn");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
